detector_pixel_scheduler: RTL and testbench

- Round-robin scheduler that shares one fixed-latency pixel-array processing stage between NUM_REQ pixel-array sources, for example the clean, edge-injected and noisy streams in the detector.
- Accepts one NUM_PIXELS-wide pixel array per cycle from the winning requester and issues it to the shared stage.
- Tracks requester ownership through the stage's latency and routes each result back to its originator.
- Bounds in-flight work per requester with credit counters.

---
 rtl/detector_pixel_scheduler_if.sv | 28 ++
 rtl/detector_pixel_scheduler.sv | 153 +++++++++++++++
 tb/tb_detector_pixel_scheduler.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/detector_pixel_scheduler_if.sv
// Request, shared-stage and response buses between the pixel-array sources,
// the scheduler and the shared fixed-latency processing stage.
interface detector_pixel_scheduler_if #(
    parameter int NUM_REQ     = 3,
    parameter int PIXEL_WIDTH = 8,
    parameter int NUM_PIXELS  = 5
);
    localparam int ARRAY_W = NUM_PIXELS * PIXEL_WIDTH;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*ARRAY_W-1:0] req_data;
    logic                       dp_valid;
    logic [ARRAY_W-1:0]         dp_data;
    logic [ARRAY_W-1:0]         dp_result;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [ARRAY_W-1:0]         rsp_data;

    modport master (
        output req_valid, req_data, dp_result,
        input  req_ready, dp_valid, dp_data, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, dp_result,
        output req_ready, dp_valid, dp_data, rsp_valid, rsp_data
    );
endinterface

// File: rtl/detector_pixel_scheduler.sv
// Round-robin scheduler sharing one fixed-latency pixel-array stage between
// NUM_REQ sources, with per-source credits and result routing by tag.
module detector_pixel_scheduler #(
    parameter int NUM_REQ         = 3,
    parameter int PIXEL_WIDTH     = 8,
    parameter int NUM_PIXELS      = 5,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    detector_pixel_scheduler_if.slave bus,
    output logic                      busy,
    output logic [15:0]               grant_count
);
    localparam int ARRAY_W = NUM_PIXELS * PIXEL_WIDTH;
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   outstanding_q [NUM_REQ];
    logic [CNT_W-1:0]   outstanding_d [NUM_REQ];
    logic               dp_valid_q, dp_valid_d;
    logic [ARRAY_W-1:0] dp_data_q, dp_data_d;
    logic [IDX_W-1:0]   dp_idx_q, dp_idx_d;
    logic [LATENCY-1:0] tag_valid_q, tag_valid_d;
    logic [IDX_W-1:0]   tag_idx_q [LATENCY];
    logic [IDX_W-1:0]   tag_idx_d [LATENCY];
    logic [15:0]        grant_count_q, grant_count_d;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] grant_oh;
    logic [NUM_REQ-1:0] rsp_oh;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               any_outstanding;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = bus.req_valid[i] & enable & ~reset & (outstanding_q[i] < CNT_MAX);
        end
    end

    // Scan from the farthest offset down so the nearest eligible index above ptr wins.
    always_comb begin
        int cand;
        cand      = 0;
        grant_oh  = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = int'(ptr_q) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (elig[cand]) begin
                grant_oh       = '0;
                grant_oh[cand] = 1'b1;
                grant_idx      = IDX_W'(cand);
                grant_any      = 1'b1;
            end
        end
    end

    always_comb begin
        rsp_oh = '0;
        if (tag_valid_q[LATENCY-1]) begin
            rsp_oh[tag_idx_q[LATENCY-1]] = 1'b1;
        end
    end

    always_comb begin
        ptr_d         = ptr_q;
        dp_valid_d    = grant_any;
        dp_data_d     = dp_data_q;
        dp_idx_d      = dp_idx_q;
        grant_count_d = grant_count_q + 16'(grant_any);
        if (grant_any) begin
            ptr_d     = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
            dp_data_d = bus.req_data[int'(grant_idx)*ARRAY_W +: ARRAY_W];
            dp_idx_d  = grant_idx;
        end

        // Tags trail the issue register so the last stage lines up with dp_result.
        tag_valid_d = '0;
        for (int s = 0; s < LATENCY; s++) begin
            tag_idx_d[s] = '0;
        end
        tag_valid_d[0] = dp_valid_q;
        tag_idx_d[0]   = dp_idx_q;
        for (int s = 1; s < LATENCY; s++) begin
            tag_valid_d[s] = tag_valid_q[s-1];
            tag_idx_d[s]   = tag_idx_q[s-1];
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            outstanding_d[i] = outstanding_q[i];
            if (grant_oh[i] && !rsp_oh[i]) begin
                outstanding_d[i] = outstanding_q[i] + CNT_W'(1);
            end else if (!grant_oh[i] && rsp_oh[i] && (outstanding_q[i] != '0)) begin
                outstanding_d[i] = outstanding_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q         <= '0;
            dp_valid_q    <= 1'b0;
            dp_data_q     <= '0;
            dp_idx_q      <= '0;
            tag_valid_q   <= '0;
            grant_count_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                tag_idx_q[s] <= '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                outstanding_q[i] <= '0;
            end
        end else begin
            ptr_q         <= ptr_d;
            dp_valid_q    <= dp_valid_d;
            dp_data_q     <= dp_data_d;
            dp_idx_q      <= dp_idx_d;
            tag_valid_q   <= tag_valid_d;
            grant_count_q <= grant_count_d;
            for (int s = 0; s < LATENCY; s++) begin
                tag_idx_q[s] <= tag_idx_d[s];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                outstanding_q[i] <= outstanding_d[i];
            end
        end
    end

    always_comb begin
        any_outstanding = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            any_outstanding = any_outstanding | (outstanding_q[i] != '0);
        end
    end

    assign busy          = any_outstanding | dp_valid_q;
    assign grant_count   = grant_count_q;
    assign bus.req_ready = grant_oh;
    assign bus.dp_valid  = dp_valid_q;
    assign bus.dp_data   = dp_data_q;
    assign bus.rsp_valid = rsp_oh;
    assign bus.rsp_data  = (|rsp_oh) ? bus.dp_result : '0;
endmodule

// File: tb/tb_detector_pixel_scheduler.sv
// Directed bench: a LATENCY=2 scheduler driving a modelled two-stage pixel stage,
// plus a LATENCY=8 instance used to push a requester against its credit cap.
module tb_detector_pixel_scheduler;
    logic        clock;
    logic        reset;
    logic        enable;
    logic        busy;
    logic [15:0] grant_count;
    logic        cap_busy;
    logic [15:0] cap_grant_count;
    logic        add_one;
    logic [39:0] stage1, stage2;
    int          total;
    int          bad;

    detector_pixel_scheduler_if #(.NUM_REQ(3), .PIXEL_WIDTH(8), .NUM_PIXELS(5)) bus ();
    detector_pixel_scheduler_if #(.NUM_REQ(3), .PIXEL_WIDTH(8), .NUM_PIXELS(5)) cap_bus ();

    detector_pixel_scheduler #(
        .NUM_REQ(3), .PIXEL_WIDTH(8), .NUM_PIXELS(5), .LATENCY(2), .MAX_OUTSTANDING(4)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .bus(bus),
        .busy(busy), .grant_count(grant_count)
    );

    detector_pixel_scheduler #(
        .NUM_REQ(3), .PIXEL_WIDTH(8), .NUM_PIXELS(5), .LATENCY(8), .MAX_OUTSTANDING(4)
    ) dut_cap (
        .clock(clock), .reset(reset), .enable(1'b1), .bus(cap_bus),
        .busy(cap_busy), .grant_count(cap_grant_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Shared stage model: two register stages, optionally adding 1 to every pixel.
    always @(posedge clock) begin
        stage1 <= add_one ? (bus.dp_data + 40'h01_01_01_01_01) : bus.dp_data;
        stage2 <= stage1;
    end
    assign bus.dp_result     = stage2;
    assign cap_bus.dp_result = '0;

    function automatic logic [119:0] packData(input logic [39:0] a0, input logic [39:0] a1,
                                              input logic [39:0] a2);
        return {a2, a1, a0};
    endfunction

    function automatic logic [39:0] fill(input int value);
        logic [7:0] b;
        b = 8'(value);
        return {5{b}};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [2:0] valid, input logic [119:0] data);
        enable        = en;
        bus.req_valid = valid;
        bus.req_data  = data;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [119:0] data;
        total = 0;
        bad   = 0;
        add_one = 1'b0;
        reset = 1'b1;
        enable = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        cap_bus.req_valid = '0;
        cap_bus.req_data  = '0;
        tick();
        tick();

        // Reset: every output quiet even with all requesters asking.
        applyStimulus(1'b1, 3'b111, '1);
        checkOutput("rst.req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("rst.dp_valid", 64'(bus.dp_valid), 64'd0);
        checkOutput("rst.dp_data", 64'(bus.dp_data), 64'd0);
        checkOutput("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rst.busy", 64'(busy), 64'd0);
        checkOutput("rst.grant_count", 64'(grant_count), 64'd0);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 3'b000, '0);
        tick();

        // Credit cap on the LATENCY=8 instance: requester 1 alone.
        cap_bus.req_valid = 3'b010;
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) tick();
            #1;
            checkOutput($sformatf("cap.ready k%0d", k), 64'(cap_bus.req_ready),
                        ((k <= 3) || (k >= 10 && k <= 13)) ? 64'd2 : 64'd0);
            checkOutput($sformatf("cap.rsp k%0d", k), 64'(cap_bus.rsp_valid),
                        (k >= 9 && k <= 12) ? 64'd2 : 64'd0);
        end
        cap_bus.req_valid = 3'b000;
        tick();

        // Fairness: all three valid for six cycles, stage adds one per pixel.
        add_one = 1'b1;
        data = packData(fill(16'h10), fill(16'h20), fill(16'h30));
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) tick();
            applyStimulus(1'b1, (c < 6) ? 3'b111 : 3'b000, data);
            checkOutput($sformatf("fair.ready c%0d", c), 64'(bus.req_ready),
                        (c < 6) ? 64'(1 << (c % 3)) : 64'd0);
            if (c >= 1 && c <= 6) begin
                checkOutput($sformatf("fair.dp_valid c%0d", c), 64'(bus.dp_valid), 64'd1);
                checkOutput($sformatf("fair.dp_data c%0d", c), 64'(bus.dp_data),
                            64'(fill(16 * (((c - 1) % 3) + 1))));
            end
            if (c >= 3 && c <= 8) begin
                checkOutput($sformatf("fair.rsp_valid c%0d", c), 64'(bus.rsp_valid),
                            64'(1 << ((c - 3) % 3)));
                checkOutput($sformatf("fair.rsp_data c%0d", c), 64'(bus.rsp_data),
                            64'(fill(16 * (((c - 3) % 3) + 1) + 1)));
            end
            if (c == 6) checkOutput("fair.grant_count", 64'(grant_count), 64'd6);
            if (c == 9) checkOutput("fair.busy_idle", 64'(busy), 64'd0);
        end

        // Single requester, pass-through stage.
        add_one = 1'b0;
        tick();
        data = packData(40'h05_04_03_02_01, '0, '0);
        applyStimulus(1'b1, 3'b001, data);
        checkOutput("single.ready", 64'(bus.req_ready), 64'd1);
        tick();
        applyStimulus(1'b1, 3'b000, data);
        checkOutput("single.dp_valid", 64'(bus.dp_valid), 64'd1);
        checkOutput("single.dp_data", 64'(bus.dp_data), 64'h05_04_03_02_01);
        checkOutput("single.ready_off", 64'(bus.req_ready), 64'd0);
        checkOutput("single.grant_count", 64'(grant_count), 64'd7);
        checkOutput("single.busy", 64'(busy), 64'd1);
        tick();
        checkOutput("single.dp_idle", 64'(bus.dp_valid), 64'd0);
        checkOutput("single.dp_hold", 64'(bus.dp_data), 64'h05_04_03_02_01);
        checkOutput("single.rsp_early", 64'(bus.rsp_valid), 64'd0);
        tick();
        checkOutput("single.rsp_valid", 64'(bus.rsp_valid), 64'd1);
        checkOutput("single.rsp_data", 64'(bus.rsp_data), 64'h05_04_03_02_01);
        tick();
        checkOutput("single.busy_idle", 64'(busy), 64'd0);
        checkOutput("single.rsp_done", 64'(bus.rsp_valid), 64'd0);
        checkOutput("single.rsp_data0", 64'(bus.rsp_data), 64'd0);

        // Enable drop with two arrays in flight; pointer is at 1 here.
        tick();
        data = packData(40'h0A_0B_0C_0D_0E, 40'h11_12_13_14_15, '0);
        applyStimulus(1'b1, 3'b011, data);
        checkOutput("en.ready0", 64'(bus.req_ready), 64'd2);
        tick();
        applyStimulus(1'b1, 3'b011, data);
        checkOutput("en.ready1", 64'(bus.req_ready), 64'd1);
        checkOutput("en.dp_data1", 64'(bus.dp_data), 64'h11_12_13_14_15);
        tick();
        applyStimulus(1'b0, 3'b011, data);
        checkOutput("en.ready_blocked", 64'(bus.req_ready), 64'd0);
        checkOutput("en.dp_data0", 64'(bus.dp_data), 64'h0A_0B_0C_0D_0E);
        checkOutput("en.busy", 64'(busy), 64'd1);
        tick();
        checkOutput("en.ready_still", 64'(bus.req_ready), 64'd0);
        checkOutput("en.rsp1", 64'(bus.rsp_valid), 64'd2);
        checkOutput("en.rsp1_data", 64'(bus.rsp_data), 64'h11_12_13_14_15);
        checkOutput("en.grant_count", 64'(grant_count), 64'd9);
        tick();
        checkOutput("en.rsp0", 64'(bus.rsp_valid), 64'd1);
        checkOutput("en.rsp0_data", 64'(bus.rsp_data), 64'h0A_0B_0C_0D_0E);
        checkOutput("en.busy_last", 64'(busy), 64'd1);
        tick();
        checkOutput("en.busy_idle", 64'(busy), 64'd0);

        // Reset one cycle after a grant to 0 (which moved the pointer to 1).
        tick();
        applyStimulus(1'b1, 3'b001, packData(40'h21_22_23_24_25, '0, '0));
        checkOutput("rmid.ready", 64'(bus.req_ready), 64'd1);
        tick();
        applyStimulus(1'b1, 3'b000, '0);
        checkOutput("rmid.dp_valid", 64'(bus.dp_valid), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("rmid.dp_valid_clr", 64'(bus.dp_valid), 64'd0);
        checkOutput("rmid.dp_data_clr", 64'(bus.dp_data), 64'd0);
        checkOutput("rmid.busy_clr", 64'(busy), 64'd0);
        checkOutput("rmid.count_clr", 64'(grant_count), 64'd0);
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 3'b101, packData(40'h31_32_33_34_35, '0, 40'h41_42_43_44_45));
        checkOutput("rmid.ptr_restart", 64'(bus.req_ready), 64'd1);
        tick();
        applyStimulus(1'b1, 3'b000, '0);
        checkOutput("rmid.aborted_rsp", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rmid.dp_data", 64'(bus.dp_data), 64'h31_32_33_34_35);
        checkOutput("rmid.count", 64'(grant_count), 64'd1);
        tick();
        checkOutput("rmid.rsp_quiet", 64'(bus.rsp_valid), 64'd0);
        tick();
        checkOutput("rmid.rsp", 64'(bus.rsp_valid), 64'd1);
        checkOutput("rmid.rsp_data", 64'(bus.rsp_data), 64'h31_32_33_34_35);
        tick();
        checkOutput("rmid.busy_idle", 64'(busy), 64'd0);

        // grant_count wrap: requester 0 granted every cycle until the counter rolls over.
        tick();
        data = packData(40'h51_52_53_54_55, 40'h61_62_63_64_65, '0);
        applyStimulus(1'b1, 3'b001, data);
        repeat (65534) tick();
        checkOutput("wrap.ffff", 64'(grant_count), 64'hFFFF);
        checkOutput("wrap.ready_run", 64'(bus.req_ready), 64'd1);
        tick();
        applyStimulus(1'b1, 3'b110, data);
        checkOutput("wrap.zero", 64'(grant_count), 64'h0000);
        checkOutput("wrap.ready_rr", 64'(bus.req_ready), 64'd2);
        tick();
        applyStimulus(1'b1, 3'b000, data);
        checkOutput("wrap.one", 64'(grant_count), 64'd1);
        checkOutput("wrap.dp_data", 64'(bus.dp_data), 64'h61_62_63_64_65);
        repeat (4) tick();
        checkOutput("wrap.busy_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
